// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the CPU memory-port arbiter.
package mips_mem_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUS_I  = 3'd1,
    BUS_D  = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } arb_state_t;

  localparam logic [3:0]  BE_WORD         = 4'b1111;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ADDR_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/mips_cpu_mem_arbiter.sv
// Serialises fetch and data requests onto one Avalon port; data wins ties. 3 cycles/txn unstalled
// (strobe N+1, valid N+2); waitrequest freezes the command, requests are only accepted in IDLE.
module mips_cpu_mem_arbiter
  import mips_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  output logic        instr_valid,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [3:0]  data_byteenable,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        data_valid,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        protocol_err
);

  arb_state_t  state, state_nx;
  logic [31:0] address_nx, writedata_nx, instr_readdata_nx, data_readdata_nx;
  logic [3:0]  byteenable_nx;
  logic        read_nx, write_nx, instr_valid_nx, data_valid_nx, protocol_err_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      address        <= '0;
      read           <= 1'b0;
      write          <= 1'b0;
      byteenable     <= '0;
      writedata      <= '0;
      instr_readdata <= '0;
      instr_valid    <= 1'b0;
      data_readdata  <= '0;
      data_valid     <= 1'b0;
      protocol_err   <= 1'b0;
    end else begin
      state          <= state_nx;
      address        <= address_nx;
      read           <= read_nx;
      write          <= write_nx;
      byteenable     <= byteenable_nx;
      writedata      <= writedata_nx;
      instr_readdata <= instr_readdata_nx;
      instr_valid    <= instr_valid_nx;
      data_readdata  <= data_readdata_nx;
      data_valid     <= data_valid_nx;
      protocol_err   <= protocol_err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (data_read || data_write) state_nx = BUS_D;
        else if (instr_req)          state_nx = BUS_I;
      end
      BUS_I:   if (!waitrequest) state_nx = RESP_I;
      BUS_D:   if (!waitrequest) state_nx = RESP_D;
      RESP_I:  state_nx = IDLE;
      RESP_D:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs; valid pulses are set on the
  // release edge so they are visible during the RESP cycle.
  always_comb begin
    address_nx        = address;
    read_nx           = read;
    write_nx          = write;
    byteenable_nx     = byteenable;
    writedata_nx      = writedata;
    instr_readdata_nx = instr_readdata;
    data_readdata_nx  = data_readdata;
    instr_valid_nx    = 1'b0;
    data_valid_nx     = 1'b0;
    protocol_err_nx   = protocol_err;
    unique case (state)
      IDLE: begin
        if (data_read || data_write) begin
          address_nx    = word_align(data_address);
          byteenable_nx = data_byteenable;
          writedata_nx  = data_writedata;
          write_nx      = data_write;
          read_nx       = !data_write;
          if (data_read && data_write) protocol_err_nx = 1'b1;
        end else if (instr_req) begin
          address_nx    = word_align(instr_address);
          byteenable_nx = BE_WORD;
          read_nx       = 1'b1;
          write_nx      = 1'b0;
        end
      end
      BUS_I: begin
        if (!waitrequest) begin
          read_nx           = 1'b0;
          instr_readdata_nx = readdata;
          instr_valid_nx    = 1'b1;
        end
      end
      BUS_D: begin
        if (!waitrequest) begin
          read_nx       = 1'b0;
          write_nx      = 1'b0;
          data_valid_nx = 1'b1;
          if (read) data_readdata_nx = readdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Scoreboard bench for mips_cpu_mem_arbiter: stimulus pushes expected bus
// commands and completions; negedge monitors pop and compare.
module tb_mips_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_req = 1'b0;
  logic [31:0] instr_address = '0;
  logic [31:0] instr_readdata;
  logic        instr_valid;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic [31:0] data_address = '0;
  logic [3:0]  data_byteenable = '0;
  logic [31:0] data_writedata = '0;
  logic [31:0] data_readdata;
  logic        data_valid;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;
  logic        protocol_err;

  mips_cpu_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .instr_valid(instr_valid),
    .data_read(data_read), .data_write(data_write), .data_address(data_address),
    .data_byteenable(data_byteenable), .data_writedata(data_writedata),
    .data_readdata(data_readdata), .data_valid(data_valid),
    .address(address), .read(read), .write(write), .byteenable(byteenable),
    .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int unsigned cyc;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
  } bus_exp_t;

  typedef struct packed {
    int unsigned cyc;
    logic [31:0] rdata;
  } vld_exp_t;

  bus_exp_t bus_q[$];
  vld_exp_t iq[$];
  vld_exp_t dq[$];
  bus_exp_t mb;
  vld_exp_t mv;

  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int stall_left = 0;
  logic [31:0] exp_drd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // waitrequest model: stall the current command for stall_left cycles
  always @(negedge clk) begin
    if ((read || write) && stall_left > 0) begin
      waitrequest = 1'b1;
      stall_left  = stall_left - 1;
    end else begin
      waitrequest = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (read || write) begin
      if (bus_q.size() == 0) begin
        chk("bus_unexpected", 96'({read, write}), 96'(0));
      end else begin
        mb = bus_q.pop_front();
        chk("bus_cyc", 96'(cyc), 96'(mb.cyc));
        chk("bus_cmd", 96'({address, byteenable, read, write, (mb.wr ? writedata : 32'h0)}),
            96'({mb.addr, mb.be, mb.rd, mb.wr, mb.wd}));
      end
    end
  end

  always @(negedge clk) begin
    if (instr_valid) begin
      if (iq.size() == 0) begin
        chk("ivalid_unexpected", 96'(instr_valid), 96'(0));
      end else begin
        mv = iq.pop_front();
        chk("ivalid_cyc", 96'(cyc), 96'(mv.cyc));
        chk("instr_readdata", 96'(instr_readdata), 96'(mv.rdata));
      end
    end
    if (data_valid) begin
      if (dq.size() == 0) begin
        chk("dvalid_unexpected", 96'(data_valid), 96'(0));
      end else begin
        mv = dq.pop_front();
        chk("dvalid_cyc", 96'(cyc), 96'(mv.cyc));
        chk("data_readdata", 96'(data_readdata), 96'(mv.rdata));
      end
    end
  end

  task automatic wait_valid(input bit is_i);
    for (int i = 0; i < 40; i++) begin
      if (is_i ? instr_valid : data_valid) return;
      @(negedge clk);
    end
    chk(is_i ? "instr_valid_timeout" : "data_valid_timeout", 96'(0), 96'(1));
  endtask

  task automatic issue(input bit is_i, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] a_al, input logic [3:0] be, input logic [31:0] wd,
                       input logic [31:0] rv, input int stall);
    int unsigned e;
    bus_exp_t b;
    vld_exp_t v;
    @(negedge clk);
    stall_left = stall;
    readdata   = rv;
    if (is_i) begin
      instr_req     = 1'b1;
      instr_address = a;
    end else begin
      data_read       = rd;
      data_write      = wr;
      data_address    = a;
      data_byteenable = be;
      data_writedata  = wd;
    end
    e = cyc + 1;
    for (int k = 0; k <= stall; k++) begin
      b.cyc  = e + k;
      b.addr = a_al;
      b.be   = is_i ? 4'hF : be;
      b.wr   = !is_i && wr;
      b.rd   = !b.wr;
      b.wd   = b.wr ? wd : 32'h0;
      bus_q.push_back(b);
    end
    v.cyc = e + stall + 1;
    if (is_i) begin
      v.rdata = rv;
      iq.push_back(v);
    end else begin
      if (!wr) exp_drd = rv;
      v.rdata = exp_drd;
      dq.push_back(v);
    end
    wait_valid(is_i);
    instr_req  = 1'b0;
    data_read  = 1'b0;
    data_write = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_bus"}, 96'({address, writedata, byteenable, read, write}), 96'(0));
    chk({tag, "_flags"}, 96'({instr_valid, data_valid, protocol_err}), 96'(0));
    chk({tag, "_rdata"}, 96'({instr_readdata, data_readdata}), 96'(0));
  endtask

  initial begin
    int unsigned e;
    bus_exp_t b;
    vld_exp_t v;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    // Unaligned fetch, no stall
    issue(1'b1, 1'b0, 1'b0, 32'hBFC0_0003, 32'hBFC0_0000, 4'h0, 32'h0, 32'h2402_0005, 0);

    // Simultaneous fetch and data read: data first, fetch after the next IDLE
    @(negedge clk);
    instr_req       = 1'b1;
    instr_address   = 32'h0040_0008;
    data_read       = 1'b1;
    data_address    = 32'h1000_0006;
    data_byteenable = 4'b1100;
    data_writedata  = 32'h55AA_55AA;
    readdata        = 32'hDEAD_BEEF;
    stall_left      = 0;
    e = cyc + 1;
    b = '{cyc: e, addr: 32'h1000_0004, wd: 32'h0, be: 4'b1100, rd: 1'b1, wr: 1'b0};
    bus_q.push_back(b);
    v = '{cyc: e + 1, rdata: 32'hDEAD_BEEF};
    dq.push_back(v);
    exp_drd = 32'hDEAD_BEEF;
    b = '{cyc: e + 3, addr: 32'h0040_0008, wd: 32'h0, be: 4'hF, rd: 1'b1, wr: 1'b0};
    bus_q.push_back(b);
    v = '{cyc: e + 4, rdata: 32'h8C82_0004};
    iq.push_back(v);
    wait_valid(1'b0);
    data_read = 1'b0;
    readdata  = 32'h8C82_0004;
    wait_valid(1'b1);
    instr_req = 1'b0;

    // Stalled partial write: command held 4 cycles, load data untouched
    issue(1'b0, 1'b0, 1'b1, 32'h0000_1002, 32'h0000_1000, 4'b0011, 32'h0000_ABCD, 32'h1234_5678, 3);

    // Stalled byte read: data captured only on release
    issue(1'b0, 1'b1, 1'b0, 32'h0000_0044, 32'h0000_0044, 4'b0001, 32'h0, 32'h0000_00A5, 2);

    // Read and write together: write wins, error flag sticks
    issue(1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_0020, 4'hF, 32'h1122_3344, 32'hFFFF_FFFF, 0);
    chk("protocol_err_set", 96'(protocol_err), 96'(1));
    repeat (3) @(negedge clk);
    chk("protocol_err_sticky", 96'(protocol_err), 96'(1));

    // Reset during a stalled write
    @(negedge clk);
    data_write      = 1'b1;
    data_address    = 32'h0000_0100;
    data_byteenable = 4'hF;
    data_writedata  = 32'hCAFE_F00D;
    stall_left      = 10;
    e = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      b = '{cyc: e + k, addr: 32'h0000_0100, wd: 32'hCAFE_F00D, be: 4'hF, rd: 1'b0, wr: 1'b1};
      bus_q.push_back(b);
    end
    for (int i = 0; i < 20 && cyc < e + 2; i++) @(negedge clk);
    chk("reset_mid_reach", 96'(cyc), 96'(e + 2));
    reset      = 1'b1;
    data_write = 1'b0;
    @(negedge clk);
    check_reset_vals("reset_mid");
    reset      = 1'b0;
    stall_left = 0;
    exp_drd    = '0;

    repeat (6) @(negedge clk);
    chk("bus_q_leftover", 96'(bus_q.size()), 96'(0));
    chk("iq_leftover", 96'(iq.size()), 96'(0));
    chk("dq_leftover", 96'(dq.size()), 96'(0));
    chk("protocol_err_final", 96'(protocol_err), 96'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
